// File: rtl/corelet_seq.sv
// corelet_seq: instruction sequencer for one corelet tile pass.
// Emits the corelet inst word each cycle for these phases, in order:
// weight fetch (XMEM->L0), kernel load, settle, activation execute with
// concurrent OFIFO->PMEM writeback, wait for writeback, optional SFP
// accumulate/ReLU pass over PMEM, and a done pulse.
// Ports:
//   clk, reset (async, active high)
//   start                       one-cycle request, honoured only in IDLE
//   w_base/x_base/p_base        XMEM weight / XMEM activation / PMEM psum bases
//   n_act                       number of activation vectors
//   acc_en, relu_en             SFP accumulate pass enable / ReLU on its last cycle
//   l0_full, ofifo_valid        corelet status flags
//   inst                        corelet instruction word
//   busy, done, err             not-IDLE / end-of-pass pulse / sticky L0 overflow
module corelet_seq #(
  parameter int row        = 8,
  parameter int col        = 8,
  parameter int addr_w     = 11,
  parameter int inst_width = 35
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_w-1:0]     w_base,
  input  logic [addr_w-1:0]     x_base,
  input  logic [addr_w-1:0]     p_base,
  input  logic [addr_w-1:0]     n_act,
  input  logic                  acc_en,
  input  logic                  relu_en,
  input  logic                  l0_full,
  input  logic                  ofifo_valid,
  output logic [inst_width-1:0] inst,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  // inst field positions
  localparam int B_RELU  = 34;
  localparam int B_ACC   = 33;
  localparam int B_CEN_P = 32;
  localparam int B_WEN_P = 31;
  localparam int A_P_LO  = 20;
  localparam int B_CEN_X = 19;
  localparam int B_WEN_X = 18;
  localparam int A_X_LO  = 7;
  localparam int B_ORD   = 6;
  localparam int B_L0RD  = 3;
  localparam int B_L0WR  = 2;
  localparam int B_EXEC  = 1;
  localparam int B_KLD   = 0;

  // both SRAMs deselected, read mode
  localparam logic [inst_width-1:0] IDLE_WORD =
    (inst_width'(1) << B_CEN_P) | (inst_width'(1) << B_WEN_P) |
    (inst_width'(1) << B_CEN_X) | (inst_width'(1) << B_WEN_X);

  // phase counter is one bit wider than addr_w so it can reach n_act+1
  localparam int CW = addr_w + 1;

  typedef enum logic [2:0] {
    IDLE, W_FETCH, W_LOAD, W_SETTLE, X_EXEC, WB_WAIT, ACC, DONE
  } state_t;

  state_t state, state_nx;
  logic [CW-1:0]     k, n_k;
  logic [addr_w-1:0] w_q, x_q, p_q, n_q;
  logic              acc_q, relu_q;
  logic              accept;

  // writeback engine
  logic [addr_w-1:0] issued, wb_cnt;
  logic              eng_on, rd_go, wb_vld;

  assign accept = (state == IDLE) && start;
  assign n_k    = CW'(n_q);
  assign eng_on = (state == X_EXEC) || (state == WB_WAIT);
  assign rd_go  = eng_on && ofifo_valid && (issued < n_q);

  // ---- state register ----
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // ---- next state ----
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:     if (start) state_nx = W_FETCH;
      W_FETCH:  if (k == CW'(row)) state_nx = W_LOAD;
      W_LOAD:   if (k == CW'(row - 1)) state_nx = W_SETTLE;
      W_SETTLE: if (k == CW'(row + col - 1)) state_nx = (n_q == '0) ? DONE : X_EXEC;
      X_EXEC:   if (k == n_k + CW'(1)) state_nx = WB_WAIT;
      WB_WAIT:  if (wb_cnt == n_q) state_nx = acc_q ? ACC : DONE;
      ACC:      if (k == n_k) state_nx = DONE;
      DONE:     state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  // per-state cycle counter, zero on every state entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  k <= '0;
    else if (state_nx != state) k <= '0;
    else                        k <= k + CW'(1);
  end

  // pass configuration, captured only when a start is accepted
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_q <= '0; x_q <= '0; p_q <= '0; n_q <= '0;
      acc_q <= 1'b0; relu_q <= 1'b0;
    end else if (accept) begin
      w_q <= w_base; x_q <= x_base; p_q <= p_base; n_q <= n_act;
      acc_q <= acc_en; relu_q <= relu_en;
    end
  end

  // OFIFO pop, then the PMEM write one cycle later (wb_vld)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued <= '0; wb_cnt <= '0; wb_vld <= 1'b0;
    end else if (accept) begin
      issued <= '0; wb_cnt <= '0; wb_vld <= 1'b0;
    end else begin
      wb_vld <= rd_go;
      if (rd_go)  issued <= issued + addr_w'(1);
      if (wb_vld) wb_cnt <= wb_cnt + addr_w'(1);
    end
  end

  // ---- outputs ----
  always_comb begin
    inst = IDLE_WORD;
    unique case (state)
      W_FETCH: begin
        if (k < CW'(row)) begin
          inst[B_CEN_X] = 1'b0;
          inst[A_X_LO +: addr_w] = w_q + k[addr_w-1:0];
        end
        if (k != '0) inst[B_L0WR] = 1'b1;   // data lands one cycle after the read
      end
      W_LOAD: begin
        inst[B_L0RD] = 1'b1;
        inst[B_KLD]  = 1'b1;
      end
      X_EXEC: begin
        if (k < n_k) begin
          inst[B_CEN_X] = 1'b0;
          inst[A_X_LO +: addr_w] = x_q + k[addr_w-1:0];
        end
        if (k != '0 && k <= n_k) inst[B_L0WR] = 1'b1;
        if (k >= CW'(2)) begin
          inst[B_L0RD] = 1'b1;
          inst[B_EXEC] = 1'b1;
        end
      end
      ACC: begin
        if (k < n_k) begin
          inst[B_CEN_P] = 1'b0;
          inst[A_P_LO +: addr_w] = p_q + k[addr_w-1:0];
        end
        if (k != '0) inst[B_ACC] = 1'b1;
        if (k == n_k && relu_q) inst[B_RELU] = 1'b1;
      end
      default: ;
    endcase
    // engine bits overlay; they never coincide with ACC's PMEM reads
    if (rd_go) inst[B_ORD] = 1'b1;
    if (wb_vld) begin
      inst[B_CEN_P] = 1'b0;
      inst[B_WEN_P] = 1'b0;
      inst[A_P_LO +: addr_w] = p_q + wb_cnt;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         err <= 1'b0;
    else if (accept)                   err <= 1'b0;
    else if (inst[B_L0WR] && l0_full)  err <= 1'b1;
  end
endmodule

// File: tb/tb_corelet_seq.sv
// Scoreboard bench for corelet_seq: each pass pushes its full expected
// per-cycle {inst, done, err} stream; a monitor pops one entry on every
// cycle the DUT is busy or pulsing done.
module tb_corelet_seq;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [10:0] w_base = '0, x_base = '0, p_base = '0, n_act = '0;
  logic        acc_en = 1'b0, relu_en = 1'b0, l0_full = 1'b0, ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        busy, done, err;

  corelet_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .w_base(w_base), .x_base(x_base), .p_base(p_base), .n_act(n_act),
    .acc_en(acc_en), .relu_en(relu_en), .l0_full(l0_full), .ofifo_valid(ofifo_valid),
    .inst(inst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;  // bits 32,31,19,18

  typedef struct packed { logic [34:0] inst; logic done; logic err; } exp_t;
  exp_t sb[$];
  logic sb_en = 1'b1;

  int pass_cnt = 0, total = 0;
  int c_xrd, c_pwr, c_prd, c_ord, c_ex, c_acc, c_relu, c_seq;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, req, $time);
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [34:0] w, input logic d, input logic e);
    exp_t t;
    t.inst = w; t.done = d; t.err = e;
    sb.push_back(t);
  endtask

  // Expected stream for one pass with ofifo_valid held high throughout.
  task automatic push_pass(input logic [10:0] wb, xb, pb, n,
                           input logic acc, relu, full);
    logic [34:0] w;
    logic e;
    e = 1'b0;
    for (int k = 0; k <= 8; k++) begin              // W_FETCH
      w = IDLE_W;
      if (k < 8) begin w[19] = 1'b0; w[17:7] = wb + 11'(k); end
      if (k >= 1) w[2] = 1'b1;
      push(w, 1'b0, e);
      if (w[2] && full) e = 1'b1;
    end
    for (int k = 0; k < 8; k++) begin               // W_LOAD
      w = IDLE_W; w[3] = 1'b1; w[0] = 1'b1;
      push(w, 1'b0, e);
    end
    for (int k = 0; k < 16; k++) push(IDLE_W, 1'b0, e);  // W_SETTLE
    if (n != 0) begin
      for (int k = 0; k <= int'(n) + 1; k++) begin  // X_EXEC + writeback
        w = IDLE_W;
        if (k < int'(n)) begin
          w[19] = 1'b0; w[17:7] = xb + 11'(k);
          w[6] = 1'b1;
        end
        if (k >= 1 && k <= int'(n)) begin
          w[2] = 1'b1;
          w[32] = 1'b0; w[31] = 1'b0; w[30:20] = pb + 11'(k - 1);
        end
        if (k >= 2) begin w[3] = 1'b1; w[1] = 1'b1; end
        push(w, 1'b0, e);
        if (w[2] && full) e = 1'b1;
      end
      push(IDLE_W, 1'b0, e);                        // WB_WAIT, drained already
      if (acc) begin
        for (int k = 0; k <= int'(n); k++) begin    // ACC
          w = IDLE_W;
          if (k < int'(n)) begin w[32] = 1'b0; w[30:20] = pb + 11'(k); end
          if (k >= 1) w[33] = 1'b1;
          if (k == int'(n) && relu) w[34] = 1'b1;
          push(w, 1'b0, e);
        end
      end
    end
    push(IDLE_W, 1'b1, e);                          // DONE
  endtask

  task automatic monitor;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && (busy || done)) begin
        if (inst[19] == 1'b0) c_xrd++;
        if (!inst[32] && !inst[31]) c_pwr++;
        if (!inst[32] && inst[31]) c_prd++;
        if (inst[6]) c_ord++;
        if (inst[1]) c_ex++;
        if (inst[33]) c_acc++;
        if (inst[34]) c_relu++;
        if (sb_en) begin
          if (sb.size() == 0) chk("sb_underflow", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            c_seq++;
            chk($sformatf("seq[%0d]", c_seq), {27'd0, inst, done, err}, {27'd0, e.inst, e.done, e.err});
          end
        end
      end
    end
  endtask

  task automatic run_pass(input logic [10:0] wb, xb, pb, n,
                          input logic acc, relu, full, input int mid_start);
    bit got;
    push_pass(wb, xb, pb, n, acc, relu, full);
    c_xrd = 0; c_pwr = 0; c_prd = 0; c_ord = 0; c_ex = 0; c_acc = 0; c_relu = 0; c_seq = 0;
    w_base = wb; x_base = xb; p_base = pb; n_act = n;
    acc_en = acc; relu_en = relu; l0_full = full; ofifo_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    got = 0;
    for (int c = 1; c < 400; c++) begin
      if (done) begin got = 1; break; end
      if (c == mid_start) begin
        start = 1'b1; n_act = 11'd5; w_base = 11'h555; acc_en = 1'b1;
      end else start = 1'b0;
      tick;
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    tick;                                   // let the monitor see the DONE cycle
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("idle_after", {63'd0, busy}, 64'd0);
    sb.delete();
    l0_full = 1'b0; ofifo_valid = 1'b0;
  endtask

  initial begin
    fork monitor(); join_none

    // reset state
    #3;
    chk("rst_inst", 64'(inst), 64'(IDLE_W));
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err",  {63'd0, err},  64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick;

    // weight phase only, with a start pulse mid-pass that must be ignored
    run_pass(11'h010, 11'h000, 11'h000, 11'd0, 1'b0, 1'b0, 1'b0, 5);
    chk("w_xrd",  64'(c_xrd), 64'd8);
    chk("w_pwr",  64'(c_pwr), 64'd0);

    // execute + writeback with wrapping XMEM addresses
    run_pass(11'h030, 11'h7FE, 11'h100, 11'd4, 1'b0, 1'b0, 1'b0, 0);
    chk("x_exec", 64'(c_ex),  64'd4);
    chk("x_ord",  64'(c_ord), 64'd4);
    chk("x_pwr",  64'(c_pwr), 64'd4);
    chk("x_xrd",  64'(c_xrd), 64'd12);

    // accumulate with ReLU
    run_pass(11'h040, 11'h020, 11'h200, 11'd3, 1'b1, 1'b1, 1'b0, 0);
    chk("a_prd",  64'(c_prd),  64'd3);
    chk("a_acc",  64'(c_acc),  64'd3);
    chk("a_relu", 64'(c_relu), 64'd1);

    // L0 overflow: err rises, sequence still completes, err stays set in IDLE
    run_pass(11'h050, 11'h000, 11'h000, 11'd0, 1'b0, 1'b0, 1'b1, 0);
    chk("err_sticky", {63'd0, err}, 64'd1);

    // abort in X_EXEC with async reset; overflow first so err is set
    sb_en = 1'b0;
    w_base = 11'h060; x_base = 11'h070; p_base = 11'h300; n_act = 11'd4;
    acc_en = 1'b0; relu_en = 1'b0; l0_full = 1'b1; ofifo_valid = 1'b1;
    start = 1'b1;
    tick;
    start = 1'b0;
    repeat (35) tick;                       // cycle 36: X_EXEC k=2
    chk("ab_exec", {63'd0, inst[1]}, 64'd1);
    chk("ab_err_pre", {63'd0, err}, 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("ab_inst", 64'(inst), 64'(IDLE_W));
    chk("ab_busy", {63'd0, busy}, 64'd0);
    chk("ab_err",  {63'd0, err},  64'd0);
    l0_full = 1'b0; ofifo_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick;
    sb_en = 1'b1;

    // clean pass after abort, accumulate without ReLU
    run_pass(11'h7FC, 11'h010, 11'h7FF, 11'd2, 1'b1, 1'b0, 1'b0, 0);
    chk("c_relu", 64'(c_relu), 64'd0);
    chk("c_acc",  64'(c_acc),  64'd2);
    chk("c_err",  {63'd0, err}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
